snes_controller_emulator: RTL and testbench

- Controller-side end of the NES/SNES serial pad protocol: responds to the console/receiver's latch and clock and shifts out button states on a single data line.
- Used as a loopback stimulus for the receiver and as a PMOD controller emulator on the board.
- Host-driven latch and clock are asynchronous to the system clock. They are synchronised and edge-detected internally.
- All logic runs on one system clock.

---
 rtl/snes_controller_emulator.sv | 181 ++++++++++++++++++
 tb/tb_snes_controller_emulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_controller_emulator.sv
// -----------------------------------------------------------------------------
// snes_controller_emulator
//
// Controller-side end of the NES/SNES serial pad protocol. The host (console or
// receiver) drives latch and shift clock asynchronously. This block
// synchronises both pins into the system clock domain and edge-detects them.
// It then presents the button states on ctrl_data, one bit per host clock
// rising edge. A 0 on ctrl_data means the button is pressed.
//
// Parameters:
//   SNES_MODE   - 1: 16-bit SNES frame, 0: 8-bit NES frame
//   SYNC_STAGES - synchroniser depth per input pin (values below 2 are
//                 raised to 2)
//
// Ports:
//   system_clk_50MHz - system clock, all state updates on its rising edge
//   reset            - synchronous, active-high
//   buttons[11:0]    - pressed=1: A,B,Select,Start,Up,Down,Left,Right,X,Y,L,R
//   ctrl_latch       - host latch pin, asynchronous, active-high
//   ctrl_clk         - host shift clock pin, asynchronous, idles high
//   ctrl_data        - serial data to host, active-low, registered
//   bit_index[4:0]   - index of the bit on ctrl_data, saturates at frame length
//   frame_done       - one-cycle pulse once the last frame bit is shifted past
//
// Latency: a pin edge shows up on ctrl_data SYNC_STAGES+1 system cycles later.
// This is SYNC_STAGES synchroniser flops plus the output register. The extra
// edge-detect copy runs alongside the output register, so it adds no cycle.
// -----------------------------------------------------------------------------
module snes_controller_emulator #(
    parameter int SNES_MODE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        system_clk_50MHz,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        ctrl_latch,
    input  logic        ctrl_clk,
    output logic        ctrl_data,
    output logic [4:0]  bit_index,
    output logic        frame_done
);

    localparam int FRAME_BITS = (SNES_MODE != 0) ? 16 : 8;
    localparam int STAGES     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [4:0] LAST_INDEX = 5'(FRAME_BITS - 1);
    localparam logic [4:0] END_INDEX  = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADING  = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [STAGES-1:0] latch_sync;
    logic [STAGES-1:0] clk_sync;
    logic              latch_d;
    logic              clk_d;
    logic              latch_s;
    logic              clk_s;
    logic              latch_rise;
    logic              clk_rise;

    always_ff @(posedge system_clk_50MHz) begin
        if (reset) begin
            latch_sync <= '0;
            clk_sync   <= '1;
            latch_d    <= 1'b0;
            clk_d      <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[STAGES-2:0], ctrl_latch};
            clk_sync   <= {clk_sync[STAGES-2:0], ctrl_clk};
            latch_d    <= latch_s;
            clk_d      <= clk_s;
        end
    end

    assign latch_s    = latch_sync[STAGES-1];
    assign clk_s      = clk_sync[STAGES-1];
    assign latch_rise = latch_s & ~latch_d;
    assign clk_rise   = clk_s & ~clk_d;

    // ------------------------------------------------------------------
    // Load word: the MSB is frame bit 0 and is the first bit on the wire.
    // The word is the inverted buttons because the line is active-low.
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] load_word;

    generate
        if (SNES_MODE != 0) begin : g_snes_word
            // B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four
            // trailing bits that always read as released (1).
            assign load_word = ~{buttons[1], buttons[9], buttons[2], buttons[3],
                                 buttons[4], buttons[5], buttons[6], buttons[7],
                                 buttons[0], buttons[8], buttons[10], buttons[11],
                                 4'b0000};
        end else begin : g_nes_word
            // A, B, Select, Start, Up, Down, Left, Right. X/Y/L/R do not exist
            // on an NES pad.
            logic nes_unused_buttons;
            assign nes_unused_buttons = ^buttons[11:8];
            assign load_word = ~{buttons[0], buttons[1], buttons[2], buttons[3],
                                 buttons[4], buttons[5], buttons[6], buttons[7]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t                state;
    state_t                state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [4:0]            index_nxt;
    logic                  done_nxt;

    always_ff @(posedge system_clk_50MHz) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '1;
            bit_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_index  <= index_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        index_nxt = bit_index;
        done_nxt  = 1'b0;

        // A latch rising edge restarts the frame from any state. It takes
        // priority over a clock edge arriving in the same cycle.
        if (latch_rise) begin
            state_nxt = LOADING;
            shreg_nxt = load_word;
            index_nxt = '0;
        end else begin
            case (state)
                LOADING: begin
                    // While the latch is held the pad is transparent, so the
                    // word tracks the buttons. Clock edges are ignored here.
                    if (latch_s) begin
                        shreg_nxt = load_word;
                        index_nxt = '0;
                    end else begin
                        state_nxt = SHIFTING;
                    end
                end
                SHIFTING: begin
                    if (clk_rise) begin
                        shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b1};
                        if (bit_index == LAST_INDEX) begin
                            index_nxt = END_INDEX;
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            index_nxt = bit_index + 5'd1;
                        end
                    end
                end
                default: begin
                    // IDLE waits for a latch. In DONE the register is already
                    // all ones, so the line sits at 1.
                end
            endcase
        end
    end

    assign ctrl_data = shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_snes_controller_emulator.sv
// -----------------------------------------------------------------------------
// tb_snes_controller_emulator
//
// The bench drives one SNES-mode instance and one NES-mode instance from the
// same host pins and buttons.
//
// The driver tasks move the host pins. Each task also advances a frame-level
// model of each pad: the frame contents, the read position, and whether a
// frame is active. For every pin event the driver queues the outputs the model
// expects, stamped with the system cycle on which they must appear. That cycle
// is the pin edge cycle + SYNC_STAGES + 1.
//
// On every falling clock edge the monitor pops any entries that have come due.
// It then compares ctrl_data, bit_index and frame_done of both instances
// against the current expectation. A change that lands one cycle early or late
// is therefore caught.
// -----------------------------------------------------------------------------
module tb_snes_controller_emulator;

    localparam int S = 2;          // synchroniser depth used for both DUTs
    localparam int D = S + 1;      // pin edge to ctrl_data latency in cycles
    localparam int W = 46;         // queue entry width

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b1;
    logic [11:0] buttons    = '0;
    logic        ctrl_latch = 1'b0;
    logic        ctrl_clk   = 1'b1;

    logic       snes_data, nes_data;
    logic [4:0] snes_idx,  nes_idx;
    logic       snes_done, nes_done;

    snes_controller_emulator #(.SNES_MODE(1), .SYNC_STAGES(S)) dut_snes (
        .system_clk_50MHz (clk),
        .reset            (reset),
        .buttons          (buttons),
        .ctrl_latch       (ctrl_latch),
        .ctrl_clk         (ctrl_clk),
        .ctrl_data        (snes_data),
        .bit_index        (snes_idx),
        .frame_done       (snes_done)
    );

    snes_controller_emulator #(.SNES_MODE(0), .SYNC_STAGES(S)) dut_nes (
        .system_clk_50MHz (clk),
        .reset            (reset),
        .buttons          (buttons),
        .ctrl_latch       (ctrl_latch),
        .ctrl_clk         (ctrl_clk),
        .ctrl_data        (nes_data),
        .bit_index        (nes_idx),
        .frame_done       (nes_done)
    );

    int pe = 0;                      // count of rising clock edges
    always @(posedge clk) pe <= pe + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, pe, got, exp);
        end
    endtask

    // ---------------- reference model (index 0 = SNES, 1 = NES) ----------------
    int          fb[2] = '{16, 8};
    int          pos[2];
    bit          active[2];
    logic [15:0] fr[2];              // fr[m][k] = level of frame bit k

    function automatic logic [15:0] frame_of(input int m, input logic [11:0] b);
        int          snes_order[12] = '{1, 9, 2, 3, 4, 5, 6, 7, 0, 8, 10, 11};
        logic [15:0] f = '1;
        for (int k = 0; k < 12; k++) begin
            if (m == 0) f[k] = ~b[snes_order[k]];
            else if (k < 8) f[k] = ~b[k];
        end
        return f;
    endfunction

    function automatic logic m_data(input int m);
        if (pos[m] < fb[m]) return fr[m][pos[m]];
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            pos[m]    = 0;
            active[m] = 1'b0;
            fr[m]     = '1;
        end
    endfunction

    // ---------------- scoreboard queue ----------------
    // entry: {due[31:0], s_data, s_idx[4:0], s_done, n_data, n_idx[4:0], n_done}
    logic [W-1:0] exp_q[$];

    task automatic push_ev(input int due, input logic [1:0] dn);
        exp_q.push_back({32'(due), m_data(0), 5'(pos[0]), dn[0],
                                   m_data(1), 5'(pos[1]), dn[1]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Latch pulse with new buttons. With both=1, the clock pin is lowered first
    // so that its rising edge coincides with the latch rising edge.
    task automatic latch_pulse(input logic [11:0] b, input bit both);
        if (both) begin
            ctrl_clk = 1'b0;
            wait_cyc(S + 2);
        end
        buttons    = b;
        ctrl_latch = 1'b1;
        if (both) ctrl_clk = 1'b1;
        for (int m = 0; m < 2; m++) begin
            fr[m]     = frame_of(m, b);
            pos[m]    = 0;
            active[m] = 1'b1;
        end
        push_ev(pe + D, 2'b00);
        wait_cyc(int'($urandom_range(1, 4)));
        ctrl_latch = 1'b0;
        wait_cyc(D + 1);
    endtask

    // One host clock pulse. Buttons may change while the clock is low; this
    // must not affect the frame in flight.
    task automatic clk_pulse();
        logic [1:0] dn;
        dn = 2'b00;
        ctrl_clk = 1'b0;
        wait_cyc(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 1) == 1) buttons = 12'($urandom);
        ctrl_clk = 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (active[m]) begin
                pos[m]++;
                if (pos[m] == fb[m]) begin
                    active[m] = 1'b0;
                    dn[m]     = 1'b1;
                end
            end
        end
        push_ev(pe + D, dn);
        wait_cyc(int'($urandom_range(1, 3)));
    endtask

    task automatic do_reset();
        wait_cyc(D + 1);             // let in-flight pin edges land first
        reset = 1'b1;
        model_reset();
        push_ev(pe + 1, 2'b00);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
    endtask

    // ---------------- monitor ----------------
    bit           mon_en = 1'b0;
    logic [W-1:0] mon_e;
    logic [1:0]   mon_dn;
    logic         cur_sd = 1'b1, cur_nd = 1'b1;
    logic [4:0]   cur_si = '0,   cur_ni = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_dn = 2'b00;
            while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= pe) begin
                mon_e  = exp_q.pop_front();
                cur_sd = mon_e[13];
                cur_si = mon_e[12:8];
                cur_nd = mon_e[6];
                cur_ni = mon_e[5:1];
                mon_dn = mon_dn | {mon_e[0], mon_e[7]};
            end
            check("snes_ctrl_data",  32'(snes_data), 32'(cur_sd));
            check("snes_bit_index",  32'(snes_idx),  32'(cur_si));
            check("snes_frame_done", 32'(snes_done), 32'(mon_dn[0]));
            check("nes_ctrl_data",   32'(nes_data),  32'(cur_nd));
            check("nes_bit_index",   32'(nes_idx),   32'(cur_ni));
            check("nes_frame_done",  32'(nes_done),  32'(mon_dn[1]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        model_reset();
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        mon_en = 1'b1;

        // idle after reset
        wait_cyc(10);

        // A only: SNES shows 0 at bit 8, NES at bit 0. Extra clocks after the end.
        latch_pulse(12'h001, 1'b0);
        for (int k = 0; k < 20; k++) clk_pulse();

        // all D-pad: NES finishes after 8 clocks, SNES keeps going
        latch_pulse(12'h0F0, 1'b0);
        for (int k = 0; k < 12; k++) clk_pulse();
        for (int k = 0; k < 8; k++) clk_pulse();

        // relatch mid-frame with R only: no frame_done, restart at bit 0
        latch_pulse(12'h0F0, 1'b0);
        for (int k = 0; k < 5; k++) clk_pulse();
        latch_pulse(12'h800, 1'b0);
        for (int k = 0; k < 17; k++) clk_pulse();

        // reset mid-frame, then clocks without latch have no effect
        latch_pulse(12'h3C5, 1'b0);
        for (int k = 0; k < 3; k++) clk_pulse();
        do_reset();
        for (int k = 0; k < 3; k++) clk_pulse();

        // latch and clock rising together: latch wins
        latch_pulse(12'h0A5, 1'b0);
        for (int k = 0; k < 3; k++) clk_pulse();
        latch_pulse(12'h5A3, 1'b1);
        for (int k = 0; k < 4; k++) clk_pulse();

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            latch_pulse(12'($urandom), ($urandom_range(0, 3) == 0));
            n = int'($urandom_range(0, 20));
            for (int k = 0; k < n; k++) clk_pulse();
            if ($urandom_range(0, 4) == 0) do_reset();
        end

        wait_cyc(D + 4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL timeout cycle=%0d got=running expected=finished", pe);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
